// File: rtl/stereo_meter_scheduler.sv
// Time-shares one position-to-meter converter between the left and right channels
// and pairs the returned meter words into L/R frames for the display driver.
module stereo_meter_scheduler #(
   parameter int position_width = 5,
   parameter int meter_width    = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_left_valid,
   output logic                      o_left_ready,
   input  logic [position_width-1:0] i_left_position,
   input  logic                      i_right_valid,
   output logic                      o_right_ready,
   input  logic [position_width-1:0] i_right_position,
   output logic                      conv_i_valid,
   input  logic                      conv_i_ready,
   output logic [position_width-1:0] conv_i_position,
   output logic                      conv_i_is_left,
   input  logic                      conv_o_valid,
   output logic                      conv_o_ready,
   input  logic [meter_width-1:0]    conv_o_meter,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [meter_width-1:0]    o_left_meter,
   output logic [meter_width-1:0]    o_right_meter,
   output logic                      o_busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT} state_t;

   state_t                    state;
   logic                      last_left;
   logic [position_width-1:0] pos_q;
   logic                      is_left_q;
   logic                      conv_i_valid_q;
   logic                      conv_o_ready_q;
   logic                      busy_q;

   logic                      pend_l;
   logic                      pend_r;
   logic [meter_width-1:0]    meter_l;
   logic [meter_width-1:0]    meter_r;

   logic                      o_valid_q;
   logic [meter_width-1:0]    left_meter_q;
   logic [meter_width-1:0]    right_meter_q;

   logic                      grant_left;
   logic                      stall;
   logic                      accept_ok;
   logic                      take_left;
   logic                      take_right;
   logic                      result_cap;
   logic                      frame_load;

   // Round-robin: on a tie the channel not served last wins; last_left=0 means
   // right was last, so left takes the first tie after reset.
   always_comb begin
      grant_left = 1'b0;
      if (i_left_valid && i_right_valid)
         grant_left = !last_left;
      else
         grant_left = i_left_valid;
   end

   // Accepting more work is pointless while a full frame is stuck behind a
   // busy downstream: a new result would have nowhere to go.
   assign stall      = pend_l && pend_r && o_valid_q && !i_ready;
   assign accept_ok  = (state == IDLE) && !stall && !reset;
   assign take_left  = accept_ok && i_left_valid && grant_left;
   assign take_right = accept_ok && i_right_valid && !grant_left;
   assign result_cap = (state == WAIT_RESULT) && conv_o_valid;
   assign frame_load = pend_l && pend_r && (!o_valid_q || i_ready);

   assign o_left_ready    = take_left;
   assign o_right_ready   = take_right;
   assign conv_i_valid    = conv_i_valid_q;
   assign conv_i_position = pos_q;
   assign conv_i_is_left  = is_left_q;
   assign conv_o_ready    = conv_o_ready_q;
   assign o_busy          = busy_q;
   assign o_valid         = o_valid_q;
   assign o_left_meter    = left_meter_q;
   assign o_right_meter   = right_meter_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         last_left      <= 1'b0;
         pos_q          <= '0;
         is_left_q      <= 1'b0;
         conv_i_valid_q <= 1'b0;
         conv_o_ready_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take_left || take_right) begin
                  pos_q          <= take_left ? i_left_position : i_right_position;
                  is_left_q      <= take_left;
                  last_left      <= take_left;
                  conv_i_valid_q <= 1'b1;
                  busy_q         <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               if (conv_i_ready) begin
                  conv_i_valid_q <= 1'b0;
                  conv_o_ready_q <= 1'b1;
                  state          <= WAIT_RESULT;
               end
            end
            WAIT_RESULT: begin
               if (conv_o_valid) begin
                  conv_o_ready_q <= 1'b0;
                  busy_q         <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               conv_i_valid_q <= 1'b0;
               conv_o_ready_q <= 1'b0;
               busy_q         <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

   // A capture on the same edge as a frame load re-arms its flag (set wins).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_l  <= 1'b0;
         pend_r  <= 1'b0;
         meter_l <= '0;
         meter_r <= '0;
      end else begin
         if (frame_load) begin
            pend_l <= 1'b0;
            pend_r <= 1'b0;
         end
         if (result_cap) begin
            if (is_left_q) begin
               meter_l <= conv_o_meter;
               pend_l  <= 1'b1;
            end else begin
               meter_r <= conv_o_meter;
               pend_r  <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_valid_q     <= 1'b0;
         left_meter_q  <= '0;
         right_meter_q <= '0;
      end else begin
         if (frame_load) begin
            o_valid_q     <= 1'b1;
            left_meter_q  <= meter_l;
            right_meter_q <= meter_r;
         end else if (i_ready) begin
            o_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stereo_meter_scheduler.sv
// Bench for stereo_meter_scheduler: converter model, transaction scoreboard,
// vector table, directed corner sequences and a randomized run.
module tb_stereo_meter_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_left_valid = 1'b0, i_right_valid = 1'b0;
   logic [4:0]  i_left_position = '0, i_right_position = '0;
   logic        o_left_ready, o_right_ready;
   logic        conv_i_valid, conv_i_ready, conv_i_is_left;
   logic [4:0]  conv_i_position;
   logic        conv_o_valid, conv_o_ready;
   logic [31:0] conv_o_meter;
   logic        o_valid, o_busy;
   logic        i_ready = 1'b1;
   logic [31:0] o_left_meter, o_right_meter;
   logic        conv_stall = 1'b0;

   always #5 clk = ~clk;

   stereo_meter_scheduler #(.position_width(5), .meter_width(32)) dut (
      .clk(clk), .reset(reset),
      .i_left_valid(i_left_valid), .o_left_ready(o_left_ready), .i_left_position(i_left_position),
      .i_right_valid(i_right_valid), .o_right_ready(o_right_ready), .i_right_position(i_right_position),
      .conv_i_valid(conv_i_valid), .conv_i_ready(conv_i_ready), .conv_i_position(conv_i_position),
      .conv_i_is_left(conv_i_is_left), .conv_o_valid(conv_o_valid), .conv_o_ready(conv_o_ready),
      .conv_o_meter(conv_o_meter), .o_valid(o_valid), .i_ready(i_ready),
      .o_left_meter(o_left_meter), .o_right_meter(o_right_meter), .o_busy(o_busy)
   );

   // Converter model: i_ready low one cycle after an accept, result two cycles later.
   logic       cm_rdy, cm_ovalid, cm_left;
   logic [4:0] cm_pos;
   int         cm_dly;
   assign conv_i_ready = cm_rdy && !conv_stall;
   assign conv_o_valid = cm_ovalid;
   assign conv_o_meter = cm_ovalid ? (32'hA000_0000 | (32'(cm_left) << 8) | 32'(cm_pos)) : 32'h0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cm_rdy <= 1'b1; cm_ovalid <= 1'b0; cm_left <= 1'b0; cm_pos <= '0; cm_dly <= 0;
      end else begin
         cm_rdy <= 1'b1;
         if (conv_i_valid && conv_i_ready) begin
            cm_rdy <= 1'b0; cm_pos <= conv_i_position; cm_left <= conv_i_is_left; cm_dly <= 2;
         end else if (cm_dly > 1) begin
            cm_dly <= cm_dly - 1;
         end else if (cm_dly == 1) begin
            cm_ovalid <= 1'b1; cm_dly <= 0;
         end
         if (cm_ovalid && conv_o_ready) cm_ovalid <= 1'b0;
      end
   end

   int n_checks = 0, n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: condition not reached / unexpected event", name);
   endtask

   // Transaction-level reference: accepted requests in order, latest value per
   // channel, and the frames that must appear downstream.
   typedef struct { logic is_left; logic [4:0] pos; } req_t;
   typedef struct { logic [31:0] l; logic [31:0] r; } frame_t;
   req_t        acc_q[$];
   frame_t      exp_q[$];
   logic        grant_log[$];
   logic        have_l = 1'b0, have_r = 1'b0;
   logic [31:0] lat_l, lat_r;
   logic        got_l, got_r;
   logic        hold_vld = 1'b0;
   logic [31:0] hold_l, hold_r;

   function automatic logic [31:0] meter_of(input logic is_left, input logic [4:0] pos);
      return 32'hA000_0000 + (is_left ? 32'd256 : 32'd0) + {27'd0, pos};
   endfunction

   task automatic observe();
      got_l = 1'b0; got_r = 1'b0;
      if (reset) return;
      if (conv_i_valid) begin
         if (acc_q.size() == 0) fail_now("conv_orphan");
         else begin
            chk("conv_pos", {27'd0, conv_i_position}, {27'd0, acc_q[0].pos});
            chk("conv_is_left", {31'd0, conv_i_is_left}, {31'd0, acc_q[0].is_left});
         end
      end
      if (conv_o_valid && conv_o_ready) begin
         if (acc_q.size() == 0) fail_now("result_orphan");
         else begin
            req_t q = acc_q.pop_front();
            if (q.is_left) begin have_l = 1'b1; lat_l = meter_of(1'b1, q.pos); end
            else           begin have_r = 1'b1; lat_r = meter_of(1'b0, q.pos); end
            if (have_l && have_r) begin
               exp_q.push_back('{lat_l, lat_r});
               have_l = 1'b0; have_r = 1'b0;
            end
         end
      end
      if (hold_vld) begin
         chk("hold_valid", {31'd0, o_valid}, 32'd1);
         chk("hold_left", o_left_meter, hold_l);
         chk("hold_right", o_right_meter, hold_r);
      end
      hold_vld = o_valid && !i_ready;
      hold_l = o_left_meter; hold_r = o_right_meter;
      if (o_valid && i_ready) begin
         if (exp_q.size() == 0) fail_now("frame_unexpected");
         else begin
            frame_t f = exp_q.pop_front();
            chk("frame_left", o_left_meter, f.l);
            chk("frame_right", o_right_meter, f.r);
         end
      end
      if (i_left_valid && o_left_ready) begin
         acc_q.push_back('{1'b1, i_left_position}); grant_log.push_back(1'b1); got_l = 1'b1;
      end
      if (i_right_valid && o_right_ready) begin
         acc_q.push_back('{1'b0, i_right_position}); grant_log.push_back(1'b0); got_r = 1'b1;
      end
   endtask

   // Called at a falling edge; observes just before the next rising edge.
   task automatic tick();
      #4;
      observe();
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (o_busy && n < 40) begin tick(); n++; end
      if (o_busy) fail_now(name);
   endtask

   task automatic send(input logic is_left, input logic [4:0] pos);
      bit done = 0;
      if (is_left) begin i_left_valid = 1'b1; i_left_position = pos; end
      else         begin i_right_valid = 1'b1; i_right_position = pos; end
      for (int n = 0; n < 40 && !done; n++) begin
         tick();
         if ((is_left && got_l) || (!is_left && got_r)) done = 1;
      end
      i_left_valid = 1'b0; i_right_valid = 1'b0;
      if (!done) fail_now("send_accept");
      wait_idle("send_idle");
   endtask

   // Both channels requested together; returns on the edge o_valid rises.
   task automatic run_pair(input logic [4:0] lp, input logic [4:0] rp);
      bit dl = 0, dr = 0;
      grant_log.delete();
      i_left_valid = 1'b1; i_left_position = lp;
      i_right_valid = 1'b1; i_right_position = rp;
      for (int n = 0; n < 60 && !(dl && dr && !o_busy); n++) begin
         tick();
         if (got_l) begin dl = 1; i_left_valid = 1'b0; end
         if (got_r) begin dr = 1; i_right_valid = 1'b0; end
      end
      if (!(dl && dr && !o_busy)) fail_now("pair_complete");
      if (grant_log.size() > 0) chk("pair_first_grant_left", {31'd0, grant_log[0]}, 32'd1);
      else fail_now("pair_no_grant");
      chk("ovalid_before_frame", {31'd0, o_valid}, 32'd0);
      tick();
      chk("ovalid_one_edge_after", {31'd0, o_valid}, 32'd1);
   endtask

   typedef struct { logic [4:0] lp; logic [4:0] rp; logic [31:0] el; logic [31:0] er; } vec_t;
   vec_t vecs[4];

   initial begin
      vecs[0] = '{5'd31, 5'd10, 32'hA000_011F, 32'hA000_000A};
      vecs[1] = '{5'd0,  5'd31, 32'hA000_0100, 32'hA000_001F};
      vecs[2] = '{5'd5,  5'd5,  32'hA000_0105, 32'hA000_0005};
      vecs[3] = '{5'd16, 5'd1,  32'hA000_0110, 32'hA000_0001};

      @(negedge clk);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_conv_i_valid", {31'd0, conv_i_valid}, 32'd0);
      chk("rst_left_meter", o_left_meter, 32'd0);
      reset = 1'b0;
      tick();

      // Vector table: simultaneous requests, i_ready high, one pulse per frame.
      foreach (vecs[i]) begin
         run_pair(vecs[i].lp, vecs[i].rp);
         chk("vec_left", o_left_meter, vecs[i].el);
         chk("vec_right", o_right_meter, vecs[i].er);
         tick();
         chk("vec_single_pulse", {31'd0, o_valid}, 32'd0);
      end

      // Left only twice: no frame; newest left wins once right arrives.
      send(1'b1, 5'd13);
      send(1'b1, 5'd9);
      tick();
      chk("left_only_no_frame", {31'd0, o_valid}, 32'd0);
      send(1'b0, 5'd3);
      tick();
      chk("newest_valid", {31'd0, o_valid}, 32'd1);
      chk("newest_left", o_left_meter, 32'hA000_0109);
      chk("newest_right", o_right_meter, 32'hA000_0003);
      tick();

      // Continuous requests alternate L,R,L,R.
      grant_log.delete();
      i_left_valid = 1'b1; i_left_position = 5'd4;
      i_right_valid = 1'b1; i_right_position = 5'd8;
      for (int n = 0; n < 80 && grant_log.size() < 4; n++) tick();
      i_left_valid = 1'b0; i_right_valid = 1'b0;
      if (grant_log.size() < 4) fail_now("rr_grants");
      else begin
         chk("rr_g0", {31'd0, grant_log[0]}, 32'd1);
         chk("rr_g1", {31'd0, grant_log[1]}, 32'd0);
         chk("rr_g2", {31'd0, grant_log[2]}, 32'd1);
         chk("rr_g3", {31'd0, grant_log[3]}, 32'd0);
      end
      wait_idle("rr_idle");
      tick(); tick();

      // Backpressure: second frame held off until i_ready returns.
      i_ready = 1'b0;
      run_pair(5'd2, 5'd4);
      send(1'b1, 5'd7);
      send(1'b0, 5'd20);
      i_left_valid = 1'b1; i_left_position = 5'd1;
      i_right_valid = 1'b1; i_right_position = 5'd2;
      for (int n = 0; n < 5; n++) begin
         chk("bp_left_ready", {31'd0, o_left_ready}, 32'd0);
         chk("bp_right_ready", {31'd0, o_right_ready}, 32'd0);
         tick();
      end
      chk("bp_held_left", o_left_meter, 32'hA000_0102);
      chk("bp_held_right", o_right_meter, 32'hA000_0004);
      i_left_valid = 1'b0; i_right_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      chk("bp_second_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_second_left", o_left_meter, 32'hA000_0107);
      chk("bp_second_right", o_right_meter, 32'hA000_0014);
      tick();
      chk("bp_drop", {31'd0, o_valid}, 32'd0);

      // Converter input stall: request held, nothing else accepted.
      conv_stall = 1'b1;
      i_left_valid = 1'b1; i_left_position = 5'd17;
      i_right_valid = 1'b1; i_right_position = 5'd22;
      tick();
      chk("stall_left_taken", {31'd0, got_l}, 32'd1);
      i_left_valid = 1'b0;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("stall_conv_valid", {31'd0, conv_i_valid}, 32'd1);
         chk("stall_busy", {31'd0, o_busy}, 32'd1);
         chk("stall_no_accept", {31'd0, o_right_ready}, 32'd0);
         chk("stall_pos", {27'd0, conv_i_position}, 32'd17);
      end
      conv_stall = 1'b0;
      for (int n = 0; n < 40 && i_right_valid; n++) begin
         tick();
         if (got_r) i_right_valid = 1'b0;
      end
      if (i_right_valid) begin fail_now("stall_right"); i_right_valid = 1'b0; end
      wait_idle("stall_idle");
      tick(); tick();

      // Reset during WAIT_RESULT with the right channel already pending.
      send(1'b0, 5'd5);
      i_left_valid = 1'b1; i_left_position = 5'd6;
      for (int n = 0; n < 20 && !conv_o_ready; n++) begin
         tick();
         if (got_l) i_left_valid = 1'b0;
      end
      i_left_valid = 1'b0;
      if (!conv_o_ready) fail_now("reach_wait_result");
      i_left_valid = 1'b1; i_right_valid = 1'b1;
      reset = 1'b1;
      #1;
      chk("ar_valid", {31'd0, o_valid}, 32'd0);
      chk("ar_left_meter", o_left_meter, 32'd0);
      chk("ar_right_meter", o_right_meter, 32'd0);
      chk("ar_conv_i_valid", {31'd0, conv_i_valid}, 32'd0);
      chk("ar_conv_o_ready", {31'd0, conv_o_ready}, 32'd0);
      chk("ar_busy", {31'd0, o_busy}, 32'd0);
      chk("ar_left_ready", {31'd0, o_left_ready}, 32'd0);
      chk("ar_right_ready", {31'd0, o_right_ready}, 32'd0);
      i_left_valid = 1'b0; i_right_valid = 1'b0;
      acc_q.delete(); exp_q.delete(); have_l = 1'b0; have_r = 1'b0; hold_vld = 1'b0;
      @(negedge clk);
      tick();
      reset = 1'b0;
      for (int n = 0; n < 4; n++) tick();
      chk("post_reset_no_frame", {31'd0, o_valid}, 32'd0);
      run_pair(5'd11, 5'd12);
      chk("post_reset_left", o_left_meter, 32'hA000_010B);
      chk("post_reset_right", o_right_meter, 32'hA000_000C);
      tick();

      // Randomized traffic against the scoreboard.
      for (int n = 0; n < 400; n++) begin
         i_left_valid     = 1'($urandom_range(0, 1));
         i_right_valid    = 1'($urandom_range(0, 1));
         i_left_position  = 5'($urandom_range(0, 31));
         i_right_position = 5'($urandom_range(0, 31));
         i_ready          = ($urandom_range(0, 3) != 0);
         conv_stall       = ($urandom_range(0, 7) == 0);
         tick();
      end
      i_left_valid = 1'b0; i_right_valid = 1'b0; i_ready = 1'b1; conv_stall = 1'b0;
      for (int n = 0; n < 40; n++) tick();
      chk("drain_requests", acc_q.size(), 32'd0);
      chk("drain_frames", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
